// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (NOT/AND/OR/XOR) between two
// requesters, with registered operands/result and a wrapping completion counter.
module logic16_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t             state;
    state_t             state_next;
    logic               last_grant;
    logic               grant;
    logic               accept;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               src_q;
    logic [WIDTH-1:0]   result;

    // Grant selection: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset && state == IDLE) begin
            req0_ready = req0_valid && !grant;
            req1_ready = req1_valid &&  grant;
        end
    end

    assign accept = req0_ready || req1_ready;
    assign busy   = (state != IDLE);

    // The shared unit only ever sees the captured operands.
    always_comb begin
        result = '0;
        case (op_q)
            2'b00: result = ~a_q;
            2'b01: result = a_q & b_q;
            2'b10: result = a_q | b_q;
            2'b11: result = a_q ^ b_q;
            default: result = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = EXEC;
            EXEC: state_next = HOLD;
            HOLD: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= 1'b0;
            done_count <= '0;
            last_grant <= 1'b1;
            op_q       <= 2'b00;
            a_q        <= '0;
            b_q        <= '0;
            src_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q  <= grant ? req1_op : req0_op;
                a_q   <= grant ? req1_a  : req0_a;
                b_q   <= grant ? req1_b  : req0_b;
                src_q <= grant;
            end
            if (state == EXEC) begin
                out_data  <= result;
                out_src   <= src_q;
                out_valid <= 1'b1;
            end
            if (state == HOLD && out_ready) begin
                out_valid  <= 1'b0;
                last_grant <= src_q;
                done_count <= done_count + 1'b1;
            end
        end
    end

endmodule
